// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for an 8-entry, 10-bit dual-address memory.
// It turns push/pop requests into memory wr_en/rd_en/wr_add/rd_add, tracks
// occupancy, and raises full/empty, almost-full/almost-empty and sticky error flags.
// valid_out is registered so that it lines up with the memory's registered read data.
//
// Ports:
//   clk, reset     rising-edge clock; synchronous active-high reset
//   push, pop      write / read requests from the transaction layer
//   data_in        write data; mem_data_in is a combinational copy of it
//   wr_en, rd_en   accepted push / pop (combinational)
//   wr_add, rd_add 4-bit memory addresses, zero-extended from the pointers
//   valid_out      high in the cycle the memory output holds a popped word
//   count          registered occupancy, 0..DEPTH
//   full, empty, almost_full, almost_empty   decoded from count
//   err_overflow   sticky: push refused because the FIFO was full
//   err_underflow  sticky: pop attempted while empty
module fifo_ctrl #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        wr_add,
  output logic [3:0]        rd_add,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C     = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C     = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    // Requests are refused outright while reset is held so the memory sees no traffic.
    pop_ok       = pop & ~empty & ~reset;
    // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
    push_ok      = push & (~full | pop_ok) & ~reset;
    wr_en        = push_ok;
    rd_en        = pop_ok;
    wr_add       = 4'(wr_ptr);
    rd_add       = 4'(rd_ptr);
    mem_data_in  = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      valid_out     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      valid_out     <= pop_ok;
      err_overflow  <= err_overflow  | (push & ~push_ok);
      err_underflow <= err_underflow | (pop & empty);
    end
  end

endmodule
